ex_alu_cntrl_seq: RTL and testbench

Registered, handshaked successor to the single-cycle EX-stage ALU control decoder. It accepts a full 32-bit instruction and decodes it into the ALU control code plus operand-select flags, holding the result in one output register.
- Adds optional RV32M decode (parameter EN_M) with a multi-cycle occupancy sequencer, synchronous flush, and illegal-op flagging.
- Sits between ID/EX pipeline register and ALU/mul-div unit.

---
 rtl/ex_alu_cntrl_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_alu_cntrl_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_cntrl_seq.sv
// Registered, handshaked EX-stage ALU control decoder with optional RV32M decode.
// Multi-cycle ops hold off new issue for MUL_LAT/DIV_LAT cycles after their output transfer.
module ex_alu_cntrl_seq #(
    parameter int CTRL_W  = 5,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              op_b_imm,
    output logic              op_a_pc,
    output logic              illegal,
    output logic              mc_busy,
    output logic              mc_done
);

    localparam logic [CTRL_W-1:0] ALU_NOOP     = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ALU_ADD      = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ALU_SUBTRACT = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] ALU_AND      = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] ALU_OR       = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] ALU_SLL      = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] ALU_SRA      = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] ALU_SRL      = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] ALU_XOR      = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] ALU_SLT      = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] ALU_SLTU     = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] ALU_MUL      = CTRL_W'(16);
    localparam logic [CTRL_W-1:0] ALU_MULH     = CTRL_W'(17);
    localparam logic [CTRL_W-1:0] ALU_MULHSU   = CTRL_W'(18);
    localparam logic [CTRL_W-1:0] ALU_MULHU    = CTRL_W'(19);
    localparam logic [CTRL_W-1:0] ALU_DIV      = CTRL_W'(20);
    localparam logic [CTRL_W-1:0] ALU_DIVU     = CTRL_W'(21);
    localparam logic [CTRL_W-1:0] ALU_REM      = CTRL_W'(22);
    localparam logic [CTRL_W-1:0] ALU_REMU     = CTRL_W'(23);

    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_MULTI} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic [CTRL_W-1:0]  dec_ctrl, ctrl_q;
    logic               dec_imm, imm_q;
    logic               dec_pc, pc_q;
    logic               dec_illegal, illegal_q;
    logic               dec_multi, multi_q;
    logic               dec_div, div_q;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Opcode/funct patterns are disjoint, so the nested case realises the priority list exactly.
    always_comb begin
        dec_ctrl    = ALU_NOOP;
        dec_imm     = 1'b0;
        dec_pc      = 1'b0;
        dec_illegal = 1'b1;
        dec_multi   = 1'b0;
        dec_div     = 1'b0;
        case (opcode)
            OPC_REG: begin
                if (funct7 == 7'b0000000) begin
                    dec_illegal = 1'b0;
                    case (funct3)
                        3'b000:  dec_ctrl = ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b010:  dec_ctrl = ALU_SLT;
                        3'b011:  dec_ctrl = ALU_SLTU;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b101:  dec_ctrl = ALU_SRL;
                        3'b110:  dec_ctrl = ALU_OR;
                        default: dec_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_illegal = 1'b0;
                    dec_ctrl    = ALU_SUBTRACT;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_illegal = 1'b0;
                    dec_ctrl    = ALU_SRA;
                end else if (EN_M != 0 && funct7 == 7'b0000001) begin
                    dec_illegal = 1'b0;
                    dec_multi   = 1'b1;
                    dec_div     = funct3[2];
                    case (funct3)
                        3'b000:  dec_ctrl = ALU_MUL;
                        3'b001:  dec_ctrl = ALU_MULH;
                        3'b010:  dec_ctrl = ALU_MULHSU;
                        3'b011:  dec_ctrl = ALU_MULHU;
                        3'b100:  dec_ctrl = ALU_DIV;
                        3'b101:  dec_ctrl = ALU_DIVU;
                        3'b110:  dec_ctrl = ALU_REM;
                        default: dec_ctrl = ALU_REMU;
                    endcase
                end
            end
            OPC_IMM: begin
                case (funct3)
                    3'b000: begin dec_ctrl = ALU_ADD;  dec_illegal = 1'b0; end
                    3'b010: begin dec_ctrl = ALU_SLT;  dec_illegal = 1'b0; end
                    3'b011: begin dec_ctrl = ALU_SLTU; dec_illegal = 1'b0; end
                    3'b100: begin dec_ctrl = ALU_XOR;  dec_illegal = 1'b0; end
                    3'b110: begin dec_ctrl = ALU_OR;   dec_illegal = 1'b0; end
                    3'b111: begin dec_ctrl = ALU_AND;  dec_illegal = 1'b0; end
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_ctrl    = ALU_SLL;
                            dec_illegal = 1'b0;
                        end
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            dec_ctrl    = ALU_SRL;
                            dec_illegal = 1'b0;
                        end else if (funct7 == 7'b0100000) begin
                            dec_ctrl    = ALU_SRA;
                            dec_illegal = 1'b0;
                        end
                    end
                endcase
                dec_imm = !dec_illegal;
            end
            OPC_LUI: begin
                dec_illegal = 1'b0;
                dec_imm     = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec_illegal = 1'b0;
                dec_ctrl    = ALU_ADD;
                dec_imm     = 1'b1;
                dec_pc      = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    dec_illegal = 1'b0;
                    dec_ctrl    = ALU_ADD;
                    dec_imm     = 1'b1;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) state_d = ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (multi_q) begin
                            state_d = ST_MULTI;
                            cnt_d   = div_q ? DIV_CNT : MUL_CNT;
                        end else if (in_valid) begin
                            state_d = ST_VALID;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_MULTI: begin
                    if (cnt == '0) state_d = ST_IDLE;
                    else           cnt_d   = cnt - 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready    = !flush && (state == ST_IDLE ||
                                 (state == ST_VALID && out_ready && !multi_q));
        out_valid   = (state == ST_VALID);
        mc_busy     = (state == ST_MULTI);
        mc_done     = (state == ST_MULTI) && (cnt == '0) && !flush;
        alu_control = ctrl_q;
        op_b_imm    = imm_q;
        op_a_pc     = pc_q;
        illegal     = illegal_q;
    end

    // Decoded-field register; a flush also clears it so no stale illegal flag lingers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= ALU_NOOP;
            imm_q     <= 1'b0;
            pc_q      <= 1'b0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
            div_q     <= 1'b0;
        end else if (flush) begin
            ctrl_q    <= ALU_NOOP;
            imm_q     <= 1'b0;
            pc_q      <= 1'b0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
            div_q     <= 1'b0;
        end else if (in_valid && in_ready) begin
            ctrl_q    <= dec_ctrl;
            imm_q     <= dec_imm;
            pc_q      <= dec_pc;
            illegal_q <= dec_illegal;
            multi_q   <= dec_multi;
            div_q     <= dec_div;
        end
    end

endmodule

// File: tb/tb_ex_alu_cntrl_seq.sv
// Directed testbench for ex_alu_cntrl_seq: one RV32M-enabled instance and one with RV32M disabled,
// both driven by the same stimulus.
module tb_ex_alu_cntrl_seq;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_ADDI = 32'h00A10093;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_DIV  = 32'h023140B3;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    localparam int C_NOOP = 0;
    localparam int C_ADD  = 1;
    localparam int C_SUB  = 2;
    localparam int C_MUL  = 16;
    localparam int C_DIV  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, op_b_imm, op_a_pc, illegal, mc_busy, mc_done;
    logic [4:0]  alu_control;
    logic        n_in_ready, n_out_valid, n_op_b_imm, n_op_a_pc, n_illegal, n_mc_busy, n_mc_done;
    logic [4:0]  n_alu_control;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_alu_cntrl_seq #(.CTRL_W(5), .EN_M(1), .MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .op_b_imm(op_b_imm), .op_a_pc(op_a_pc),
        .illegal(illegal), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    ex_alu_cntrl_seq #(.CTRL_W(5), .EN_M(0), .MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut_nom (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .instr(instr), .out_valid(n_out_valid), .out_ready(out_ready),
        .alu_control(n_alu_control), .op_b_imm(n_op_b_imm), .op_a_pc(n_op_a_pc),
        .illegal(n_illegal), .mc_busy(n_mc_busy), .mc_done(n_mc_done)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] i, input logic r, input logic f);
        @(negedge clk);
        in_valid  = v;
        instr     = i;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        int nom_busy;

        applyStimulus(0, '0, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_alu_control", alu_control, C_NOOP);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_mc_busy", mc_busy, 0);
        checkOutput("rst_mc_done", mc_done, 0);
        @(negedge clk);
        rst = 1'b1;

        // single add
        applyStimulus(1, I_ADD, 1, 0);
        checkOutput("add_in_ready_idle", in_ready, 1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("add_out_valid", out_valid, 1);
        checkOutput("add_ctrl", alu_control, C_ADD);
        checkOutput("add_imm", op_b_imm, 0);
        checkOutput("add_illegal", illegal, 0);
        checkOutput("add_in_ready", in_ready, 1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("add_drain", out_valid, 0);

        // backpressure: addi held, then sub
        applyStimulus(1, I_ADDI, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, I_SUB, 0, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_ctrl", alu_control, C_ADD);
            checkOutput("bp_imm", op_b_imm, 1);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        applyStimulus(1, I_SUB, 1, 0);
        checkOutput("bp_release_ready", in_ready, 1);
        checkOutput("bp_release_ctrl", alu_control, C_ADD);
        applyStimulus(0, '0, 1, 0);
        checkOutput("sub_out_valid", out_valid, 1);
        checkOutput("sub_ctrl", alu_control, C_SUB);
        checkOutput("sub_imm", op_b_imm, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("sub_no_dup", out_valid, 0);

        // mul, 4 busy cycles
        applyStimulus(1, I_MUL, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("mul_out_valid", out_valid, 1);
        checkOutput("mul_ctrl", alu_control, C_MUL);
        checkOutput("mul_illegal", illegal, 0);
        checkOutput("nom_mul_ctrl", n_alu_control, C_NOOP);
        checkOutput("nom_mul_illegal", n_illegal, 1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("mul_valid_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, '0, 1, 0);
            checkOutput("mul_busy", mc_busy, 1);
            checkOutput("mul_busy_in_ready", in_ready, 0);
            checkOutput("mul_busy_out_valid", out_valid, 0);
            checkOutput("mul_done", mc_done, (k == 3) ? 1 : 0);
            checkOutput("nom_mul_busy", n_mc_busy, 0);
        end
        applyStimulus(0, '0, 1, 0);
        checkOutput("mul_after_busy", mc_busy, 0);
        checkOutput("mul_after_ready", in_ready, 1);
        checkOutput("mul_after_done", mc_done, 0);

        // div, 33 busy cycles; illegal on the EN_M=0 instance
        applyStimulus(1, I_DIV, 1, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("div_out_valid", out_valid, 1);
        checkOutput("div_ctrl", alu_control, C_DIV);
        checkOutput("nom_div_ctrl", n_alu_control, C_NOOP);
        checkOutput("nom_div_illegal", n_illegal, 1);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        nom_busy = 0;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(0, '0, 1, 0);
            if (mc_busy) busy_cnt++;
            if (mc_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (n_mc_busy) nom_busy = 1;
            if (!mc_busy && busy_cnt > 0) break;
        end
        checkOutput("div_busy_cycles", busy_cnt, 33);
        checkOutput("div_done_count", done_cnt, 1);
        checkOutput("div_done_last", done_at, 33);
        checkOutput("nom_div_busy", nom_busy, 0);

        // flush in the 2nd MULTI cycle
        applyStimulus(1, I_MUL, 1, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("fl_mul_valid", out_valid, 1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("fl_busy1", mc_busy, 1);
        applyStimulus(0, '0, 1, 1);
        checkOutput("fl_done_suppr", mc_done, 0);
        checkOutput("fl_in_ready", in_ready, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("fl_busy_clear", mc_busy, 0);
        checkOutput("fl_ready_back", in_ready, 1);
        checkOutput("fl_out_valid", out_valid, 0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, '0, 1, 0);
            if (mc_done) done_cnt++;
        end
        checkOutput("fl_no_done", done_cnt, 0);

        // flush with in_valid in IDLE
        applyStimulus(1, I_ADD, 1, 1);
        checkOutput("fl_idle_ready", in_ready, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("fl_idle_no_valid", out_valid, 0);

        // flush coinciding with the final count
        applyStimulus(1, I_MUL, 1, 0);
        applyStimulus(0, '0, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 1, 1);
        checkOutput("fl_last_busy", mc_busy, 1);
        checkOutput("fl_last_done", mc_done, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("fl_last_idle", mc_busy, 0);

        // async reset mid-VALID
        applyStimulus(1, I_BAD, 0, 0);
        applyStimulus(0, '0, 0, 0);
        checkOutput("bad_out_valid", out_valid, 1);
        checkOutput("bad_illegal", illegal, 1);
        checkOutput("bad_ctrl", alu_control, C_NOOP);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_illegal", illegal, 0);
        checkOutput("arst_mc_busy", mc_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, I_ADD, 1, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("post_rst_valid", out_valid, 1);
        checkOutput("post_rst_ctrl", alu_control, C_ADD);
        checkOutput("post_rst_illegal", illegal, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
